// File: rtl/stitch_pipeline_ready.sv
// stitch_pipeline_ready: STAGES-deep add-STEP pipeline with chained valid/ready backpressure,
// synchronous flush and an output transfer counter.
module stitch_pipeline_ready #(
    parameter int               WIDTH  = 32,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] STEP   = WIDTH'(1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             input_valid,
    output logic                             input_ready,
    input  logic [WIDTH-1:0]                 x,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out,
    output logic [$clog2(STAGES+1)-1:0]      occupancy,
    output logic [15:0]                      xfer_count
);
    localparam int OW = $clog2(STAGES+1);
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [STAGES-1:0] v_q, v_d;
    logic              rdy [STAGES+1];
    logic [15:0]       xfer_q, xfer_d;
    assign rdy[STAGES]  = out_ready;
    assign input_ready  = rdy[0] && !flush;
    assign out          = d_q[STAGES-1];
    assign out_valid    = v_q[STAGES-1];
    assign xfer_count   = xfer_q;
    assign xfer_d       = xfer_q + 16'(out_valid && out_ready && !flush);
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        if (i == 0) begin : g_head
            assign up_v = input_valid && input_ready;
            assign up_d = x;
        end else begin : g_body
            assign up_v = v_q[i-1];
            assign up_d = d_q[i-1];
        end
        // a stage can take new data when empty or when its own item moves on this cycle
        assign rdy[i] = !v_q[i] || rdy[i+1];
        assign v_d[i] = !flush && (rdy[i] ? up_v : v_q[i]);
        assign d_d[i] = (!flush && rdy[i] && up_v) ? up_d + STEP : d_q[i];
    end
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) occupancy = occupancy + OW'(v_q[k]);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q    <= '0;
            xfer_q <= '0;
            for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
        end else begin
            v_q    <= v_d;
            xfer_q <= xfer_d;
            d_q    <= d_d;
        end
    end
endmodule

// File: tb/tb_stitch_pipeline_ready.sv
// tb_stitch_pipeline_ready: item-level reference model checked every cycle, plus directed
// vectors with hand-computed expectations for a default and a 4-stage/STEP=3 instance.
module tb_stitch_pipeline_ready;
    localparam int          S    = 2;
    localparam logic [31:0] STEP = 32'd1;
    logic        clk = 0, rst = 0, flush = 0, input_valid = 0, out_ready = 0;
    logic [31:0] x = 0;
    logic        input_ready, out_valid;
    logic [31:0] out;
    logic [1:0]  occupancy;
    logic [15:0] xfer_count;
    logic        ir4, ov4;
    logic [31:0] out4;
    logic [2:0]  occ4;
    logic [15:0] xfer4;
    int          checks = 0, errors = 0;

    stitch_pipeline_ready dut (
        .clk(clk), .rst(rst), .flush(flush), .input_valid(input_valid),
        .input_ready(input_ready), .x(x), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .occupancy(occupancy), .xfer_count(xfer_count));

    stitch_pipeline_ready #(.WIDTH(32), .STAGES(4), .STEP(32'd3)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .input_valid(input_valid),
        .input_ready(ir4), .x(x), .out_valid(ov4), .out_ready(1'b1),
        .out(out4), .occupancy(occ4), .xfer_count(xfer4));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: each slot holds the original x of an item; an item in slot i has had (i+1) STEPs added.
    bit          mv [S];
    logic [31:0] mx [S];
    logic [15:0] mxfer = 0;

    function automatic int mcnt();
        int c = 0;
        foreach (mv[i]) c += int'(mv[i]);
        return c;
    endfunction

    always @(negedge rst) begin
        foreach (mv[i]) mv[i] = 0;
        mxfer = 0;
    end

    always @(posedge clk) begin
        bit          nv [S];
        logic [31:0] nx [S];
        bit          acc, drn;
        if (rst) begin
            if (flush) begin
                foreach (mv[i]) mv[i] = 0;
            end else begin
                acc = input_valid && (out_ready || mcnt() < S);
                drn = out_ready && mv[S-1];
                if (drn) mxfer++;
                foreach (nv[i]) begin nv[i] = 0; nx[i] = '0; end
                for (int i = S - 1; i >= 0; i--) begin
                    if (mv[i]) begin
                        if (i == S - 1) begin
                            if (!drn) begin nv[i] = 1; nx[i] = mx[i]; end
                        end else if (!nv[i+1]) begin
                            nv[i+1] = 1; nx[i+1] = mx[i];
                        end else begin
                            nv[i] = 1; nx[i] = mx[i];
                        end
                    end
                end
                if (acc) begin nv[0] = 1; nx[0] = x; end
                mv = nv;
                mx = nx;
            end
        end
    end

    always @(negedge clk) begin
        chk("input_ready", input_ready, !flush && (out_ready || mcnt() < S));
        chk("occupancy", occupancy, mcnt());
        chk("out_valid", out_valid, mv[S-1]);
        if (mv[S-1]) chk("out", out, 32'(mx[S-1] + 32'(S) * STEP));
        chk("xfer_count", xfer_count, mxfer);
    end

    logic [31:0] got [$];
    always @(negedge clk) if (rst && out_valid && out_ready && !flush) got.push_back(out);

    task automatic drive(input bit iv, input logic [31:0] xv, input bit orr, input bit fl);
        input_valid = iv; x = xv; out_ready = orr; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    logic [15:0] base;
    bit          allr;

    initial begin
        drive(0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_xfer", xfer_count, 0);
        chk("rst_ready", input_ready, 1);
        rst = 1;
        drive(1, 5, 1, 0);
        @(negedge clk); chk("c0_ready", input_ready, 1);
        tick();
        drive(0, 0, 1, 0);
        @(negedge clk); chk("c1_occ", occupancy, 1); chk("c1_ov", out_valid, 0);
        tick();
        @(negedge clk); chk("c2_ov", out_valid, 1); chk("c2_out", out, 7); chk("c2_occ", occupancy, 1);
        tick();
        @(negedge clk); chk("c3_occ", occupancy, 0); chk("c3_ov", out_valid, 0); chk("c3_xfer", xfer_count, 1);
        tick();
        drive(1, 32'hFFFF_FFFF, 1, 0); tick();
        drive(0, 0, 1, 0); tick();
        @(negedge clk); chk("wrap_ov", out_valid, 1); chk("wrap_out", out, 1);
        repeat (6) tick();
        drive(1, 10, 1, 0); tick();
        drive(0, 0, 1, 0); tick(); tick();
        @(negedge clk); chk("s4_c3_ov", ov4, 0);
        tick();
        @(negedge clk); chk("s4_c4_ov", ov4, 1); chk("s4_c4_out", out4, 22);
        repeat (3) tick();
        got.delete();
        drive(1, 1, 0, 0); @(negedge clk); chk("bp_ready0", input_ready, 1); tick();
        drive(1, 2, 0, 0); @(negedge clk); chk("bp_ready1", input_ready, 1); tick();
        drive(1, 3, 0, 0); @(negedge clk); chk("bp_ready2", input_ready, 0); chk("bp_occ", occupancy, 2); tick();
        drive(1, 3, 1, 0); @(negedge clk); chk("bp_ready3", input_ready, 1); tick();
        drive(1, 4, 1, 0); tick();
        drive(0, 0, 1, 0); repeat (4) tick();
        chk("bp_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) chk("bp_order", got[k], k + 3);
        base = xfer_count;
        allr = 1;
        for (int k = 0; k < 100; k++) begin
            drive(1, k, 1, 0);
            @(negedge clk); if (!input_ready) allr = 0;
            tick();
        end
        drive(0, 0, 1, 0); repeat (4) tick();
        chk("stream_ready", allr, 1);
        chk("stream_xfer", 16'(xfer_count - base), 100);
        drive(1, 7, 0, 0); tick();
        drive(1, 8, 0, 0); tick();
        @(negedge clk); chk("fl_full", occupancy, 2);
        base = xfer_count;
        drive(1, 99, 1, 1); @(negedge clk); chk("fl_ready", input_ready, 0); tick();
        drive(0, 0, 1, 0);
        @(negedge clk); chk("fl_occ", occupancy, 0); chk("fl_ov", out_valid, 0); chk("fl_xfer", xfer_count, base);
        repeat (3) tick();
        @(negedge clk); chk("fl_not_taken", occupancy, 0);
        tick();
        drive(1, 11, 0, 0); tick();
        drive(1, 12, 0, 0); tick();
        drive(0, 0, 0, 0);
        @(negedge clk); chk("ar_full", occupancy, 2);
        @(posedge clk); #3;
        rst = 0; #1;
        chk("ar_ov", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        drive(0, 0, 1, 0);
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stitch_pipeline_ready.md
STITCH_PIPELINE_READY -- requirements
Module: stitch_pipeline_ready

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 32, meaning the data width in bits (legal range 1..64).
REQ-002 The block SHALL provide parameter STAGES, default 2, meaning the number of compute/register stages (legal range 1..16).
REQ-003 The block SHALL provide parameter STEP, default 1, meaning the WIDTH-bit constant added per stage.
REQ-004 The block SHALL provide port clk, input, 1 bit, meaning the single clock; all flops sample on its rising edge.
REQ-005 The block SHALL provide port rst, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL provide port flush, input, 1 bit, meaning a synchronous pipeline clear.
REQ-007 The block SHALL provide port input_valid, input, 1 bit, meaning x is presented.
REQ-008 The block SHALL provide port input_ready, output, 1 bit, meaning stage 0 accepts this cycle.
REQ-009 The block SHALL provide port x, input, WIDTH bits, meaning the input operand.
REQ-010 The block SHALL provide port out_valid, output, 1 bit, meaning out holds a result.
REQ-011 The block SHALL provide port out_ready, input, 1 bit, meaning the consumer accepts out.
REQ-012 The block SHALL provide port out, output, WIDTH bits, meaning the result.
REQ-013 The block SHALL provide port occupancy, output, $clog2(STAGES+1) bits, meaning the count of valid stages.
REQ-014 The block SHALL provide port xfer_count, output, 16 bits, meaning the count of output transfers.

Function
REQ-015 Stage i (0..STAGES-1) SHALL own a data register d[i] and a valid bit v[i]; out = d[STAGES-1] and out_valid = v[STAGES-1].
REQ-016 Stage 0 SHALL load x + STEP; stage i>0 SHALL load d[i-1] + STEP; all sums SHALL be truncated modulo 2^WIDTH.
REQ-017 An accepted input SHALL appear at out as x + STAGES*STEP mod 2^WIDTH, STAGES cycles after acceptance, when there is no backpressure.
REQ-018 Ready SHALL chain combinationally: rdy[STAGES] = out_ready; rdy[i] = !v[i] || rdy[i+1]; input_ready = rdy[0] && !flush.
REQ-019 When rdy[i] is 1, stage i SHALL load: v[i] <= upstream valid (input_valid && input_ready for i=0, v[i-1] for i>0), and d[i] <= new sum only when that upstream valid is 1.
REQ-020 When rdy[i] is 0, stage i SHALL hold d[i] and v[i] unchanged.
REQ-021 A transfer at an interface SHALL occur exactly when valid && ready are both 1; no item SHALL be duplicated or dropped, except by flush.
REQ-022 Full-throughput requirement: with out_ready held at 1, the block SHALL accept one input per cycle indefinitely.
REQ-023 Simultaneous events: when the pipeline is full and out_ready=1, input_ready SHALL be 1 and the accept and drain SHALL occur in the same cycle.
REQ-024 A flush asserted in cycle t SHALL clear every v[i] at the edge ending cycle t.
REQ-025 The input SHALL NOT be accepted during a flush, and the output SHALL NOT count a transfer during a flush, even if out_valid && out_ready.
REQ-026 Flush SHALL take priority over every load and hold in REQ-019 and REQ-020.
REQ-027 occupancy SHALL equal the registered population count of v[], ranging from 0 to STAGES.
REQ-028 xfer_count SHALL increment by 1 on each output transfer not coincident with flush, and SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-029 While rst=0, all v[i] SHALL be 0, all d[i] SHALL be 0, and xfer_count SHALL be 0, asynchronously.
REQ-030 During and after reset, the outputs SHALL read: out_valid=0, out=0, occupancy=0, xfer_count=0.
REQ-031 During and after reset, input_ready SHALL read 1 (unless flush=1).
REQ-032 A reset asserted mid-operation SHALL discard all in-flight items.
REQ-033 The first edge after rst deasserts SHALL already be able to accept input.

Verification
REQ-034 Defaults, no backpressure: x=5 on cycle 0 with out_ready=1 -> out_valid=1 and out=7 on cycle 2; occupancy is 1 on cycles 1 and 2, then 0.
REQ-035 Wrap: WIDTH=32, x=0xFFFFFFFF -> out=0x00000001; with STAGES=4, STEP=3, x=10 -> out=22 after 4 cycles.
REQ-036 Backpressure: stream x=1,2,3,4 with out_ready=0 -> input_ready drops after 2 accepts and occupancy=2; release out_ready -> outputs are 3,4,5,6 in order with none lost.
REQ-037 Full streaming: 100 back-to-back inputs with out_ready=1 -> input_ready stays 1 and xfer_count=100.
REQ-038 Flush: flush while full with input_valid=1 and out_ready=1 -> the next cycle shows occupancy=0 and out_valid=0, the input is not taken, and xfer_count is unchanged.
REQ-039 Async reset: drop rst between clock edges with occupancy=2 -> out_valid=0 and occupancy=0 immediately, without waiting for clk.
